// File: rtl/receptor_teclado_ps2.sv
// PS/2 keyboard receiver: synchronizes and deglitches the bus, assembles 11-bit frames,
// and decodes make/break/extended scan codes into a held key plus one-cycle event pulses.
module receptor_teclado_ps2 #(
    parameter int FILTRO_CICLOS  = 8,
    parameter int TIMEOUT_CICLOS = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Tecla,
    output logic       tecla_valida,
    output logic       tecla_extendida,
    output logic       tecla_liberada,
    output logic       error_trama
);

    localparam int FW = $clog2(FILTRO_CICLOS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [FW-1:0] FILTRO_MAX  = FW'(FILTRO_CICLOS - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {REPOSO, DATOS, PARIDAD, PARADA} estado_t;

    logic [1:0]    r_clkSync;
    logic [1:0]    r_dataSync;
    logic [FW-1:0] r_filtCnt;
    logic          r_clkFilt;
    logic          r_clkFiltAnt;

    estado_t       r_estado,   w_estado;
    logic [2:0]    r_bitCnt,   w_bitCnt;
    logic [7:0]    r_shift,    w_shift;
    logic          r_paridad,  w_paridad;
    logic          r_extFlag,  w_extFlag;
    logic          r_brkFlag,  w_brkFlag;
    logic [TW-1:0] r_timeout,  w_timeout;
    logic [7:0]    r_tecla,    w_tecla;
    logic          r_teclaExt, w_teclaExt;
    logic          r_valida,   w_valida;
    logic          r_liberada, w_liberada;
    logic          r_error,    w_error;

    logic w_clkSinc;
    logic w_dataSinc;
    logic w_muestra;

    // Idle PS/2 bus is high, so synchronizers and filter come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk};
            r_dataSync <= {r_dataSync[0], ps2_data};
        end
    end

    assign w_clkSinc  = r_clkSync[1];
    assign w_dataSinc = r_dataSync[1];

    // The filtered clock flips on the FILTRO_CICLOS-th consecutive sample at the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filtCnt    <= '0;
            r_clkFilt    <= 1'b1;
            r_clkFiltAnt <= 1'b1;
        end else begin
            r_clkFiltAnt <= r_clkFilt;
            if (w_clkSinc == r_clkFilt) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FILTRO_MAX) begin
                r_clkFilt <= w_clkSinc;
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + FW'(1);
            end
        end
    end

    assign w_muestra = r_clkFiltAnt & ~r_clkFilt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado   <= REPOSO;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_paridad  <= 1'b0;
            r_extFlag  <= 1'b0;
            r_brkFlag  <= 1'b0;
            r_timeout  <= '0;
            r_tecla    <= '0;
            r_teclaExt <= 1'b0;
            r_valida   <= 1'b0;
            r_liberada <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_estado   <= w_estado;
            r_bitCnt   <= w_bitCnt;
            r_shift    <= w_shift;
            r_paridad  <= w_paridad;
            r_extFlag  <= w_extFlag;
            r_brkFlag  <= w_brkFlag;
            r_timeout  <= w_timeout;
            r_tecla    <= w_tecla;
            r_teclaExt <= w_teclaExt;
            r_valida   <= w_valida;
            r_liberada <= w_liberada;
            r_error    <= w_error;
        end
    end

    // Frame sequencing and scan-code decode; only one event pulse can be raised per cycle.
    always_comb begin
        w_estado   = r_estado;
        w_bitCnt   = r_bitCnt;
        w_shift    = r_shift;
        w_paridad  = r_paridad;
        w_extFlag  = r_extFlag;
        w_brkFlag  = r_brkFlag;
        w_tecla    = r_tecla;
        w_teclaExt = r_teclaExt;
        w_valida   = 1'b0;
        w_liberada = 1'b0;
        w_error    = 1'b0;

        if (w_muestra) begin
            w_timeout = '0;
        end else if (r_timeout != TIMEOUT_MAX) begin
            w_timeout = r_timeout + TW'(1);
        end else begin
            w_timeout = r_timeout;
        end

        if (w_muestra) begin
            case (r_estado)
                REPOSO: begin
                    if (!w_dataSinc) begin
                        w_estado = DATOS;
                        w_bitCnt = '0;
                    end
                end
                DATOS: begin
                    w_shift  = {w_dataSinc, r_shift[7:1]};
                    w_bitCnt = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_estado = PARIDAD;
                    end
                end
                PARIDAD: begin
                    w_paridad = w_dataSinc;
                    w_estado  = PARADA;
                end
                PARADA: begin
                    w_estado = REPOSO;
                    if (w_dataSinc && (^{r_paridad, r_shift})) begin
                        if (r_shift == 8'hE0) begin
                            w_extFlag = 1'b1;
                        end else if (r_shift == 8'hF0) begin
                            w_brkFlag = 1'b1;
                        end else if (r_brkFlag) begin
                            w_liberada = 1'b1;
                            w_extFlag  = 1'b0;
                            w_brkFlag  = 1'b0;
                        end else begin
                            w_tecla    = r_shift;
                            w_teclaExt = r_extFlag;
                            w_valida   = 1'b1;
                            w_extFlag  = 1'b0;
                            w_brkFlag  = 1'b0;
                        end
                    end else begin
                        w_error   = 1'b1;
                        w_extFlag = 1'b0;
                        w_brkFlag = 1'b0;
                    end
                end
                default: w_estado = REPOSO;
            endcase
        end else if (r_estado != REPOSO && r_timeout == TIMEOUT_MAX) begin
            w_estado  = REPOSO;
            w_error   = 1'b1;
            w_extFlag = 1'b0;
            w_brkFlag = 1'b0;
            w_bitCnt  = '0;
        end
    end

    assign Tecla           = r_tecla;
    assign tecla_extendida = r_teclaExt;
    assign tecla_valida    = r_valida;
    assign tecla_liberada  = r_liberada;
    assign error_trama     = r_error;

endmodule
